// File: rtl/scan_arbiter.sv
// Round-robin arbiter that scans a memory window for two requesters and reports
// the signed maximum and the number of completed peaks (rise then fall).
// Latency: LOAD one cycle after grant, then LEN scan cycles, DONE on cycle LEN+2.
// Backpressure: none; REQ is a level, the grant is held until DONE, one IDLE gap between scans.
//
// Ports:
//   CLOCK, RESET          clock and synchronous active-high reset
//   REQ[1:0]              level request per requester
//   BASE0/LEN0, BASE1/LEN1 window start and element count minus one, sampled at grant
//   MEM_DATA              combinational read data for the current MAR
//   MAR                   registered memory address
//   GNT                   one-hot grant, held for the whole scan
//   BUSY                  high whenever not idle
//   DONE, DONE_ID         one-cycle completion pulse and the requester it serves
//   MAX_OUT, NUM_OUT      window maximum and peak count, held until the next completion
module scan_arbiter #(
    parameter int AW = 5,
    parameter int DW = 9,
    parameter int NW = 5
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic [1:0]    REQ,
    input  logic [AW-1:0] BASE0,
    input  logic [AW-1:0] LEN0,
    input  logic [AW-1:0] BASE1,
    input  logic [AW-1:0] LEN1,
    input  logic [DW-1:0] MEM_DATA,
    output logic [AW-1:0] MAR,
    output logic [1:0]    GNT,
    output logic          BUSY,
    output logic          DONE,
    output logic          DONE_ID,
    output logic [DW-1:0] MAX_OUT,
    output logic [NW-1:0] NUM_OUT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [AW-1:0] A_ONE = AW'(1);
    localparam logic [NW-1:0] N_ONE = NW'(1);

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic [AW-1:0] mar_q, mar_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [DW-1:0] temp_q, temp_d;
    logic [DW-1:0] max_q, max_d;
    logic [NW-1:0] num_q, num_d;
    logic          flag_q, flag_d;
    logic          done_q, done_d;
    logic          done_id_q, done_id_d;
    logic [DW-1:0] max_out_q, max_out_d;
    logic [NW-1:0] num_out_q, num_out_d;

    logic signed [DW-1:0] data_s, temp_s, max_s;
    logic                 pick;

    assign data_s = MEM_DATA;
    assign temp_s = temp_q;
    assign max_s  = max_q;

    // Single request wins outright; a tie goes to the requester not served last.
    assign pick = (REQ == 2'b11) ? ~last_q : REQ[1];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        mar_d     = mar_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        temp_d    = temp_q;
        max_d     = max_q;
        num_d     = num_q;
        flag_d    = flag_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        max_out_d = max_out_q;
        num_out_d = num_out_q;

        case (state_q)
            S_IDLE: begin
                if (REQ != 2'b00) begin
                    sel_d   = pick;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    mar_d   = pick ? BASE1 : BASE0;
                    cnt_d   = pick ? LEN1 : LEN0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                temp_d = MEM_DATA;
                max_d  = MEM_DATA;
                num_d  = '0;
                flag_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    mar_d   = mar_q + A_ONE;
                    cnt_d   = cnt_q - A_ONE;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (data_s < temp_s) begin
                    if (flag_q) begin
                        num_d  = num_q + N_ONE;
                        flag_d = 1'b0;
                    end
                end else if (data_s > temp_s) begin
                    flag_d = 1'b1;
                    if (data_s > max_s) begin
                        max_d = MEM_DATA;
                    end
                end
                temp_d = MEM_DATA;
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    mar_d = mar_q + A_ONE;
                    cnt_d = cnt_q - A_ONE;
                end
            end
            S_FIN: begin
                gnt_d   = 2'b00;
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are registered on entry to FIN so they are visible together
        // with DONE; they include the update made by the final element.
        if (state_d == S_FIN && state_q != S_FIN) begin
            done_d    = 1'b1;
            done_id_d = sel_q;
            max_out_d = max_d;
            num_out_d = num_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            mar_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= 2'b00;
            temp_q    <= '0;
            max_q     <= '0;
            num_q     <= '0;
            flag_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            max_out_q <= '0;
            num_out_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            mar_q     <= mar_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            temp_q    <= temp_d;
            max_q     <= max_d;
            num_q     <= num_d;
            flag_q    <= flag_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            max_out_q <= max_out_d;
            num_out_q <= num_out_d;
        end
    end

    assign MAR     = mar_q;
    assign GNT     = gnt_q;
    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = done_q;
    assign DONE_ID = done_id_q;
    assign MAX_OUT = max_out_q;
    assign NUM_OUT = num_out_q;

endmodule

// File: doc/scan_arbiter.md
Name: scan_arbiter

Overview:
- Sequences a shared 32-entry, 9-bit constant-memory scan datapath on behalf of two requesters.
- Each requester supplies a start address and an element count.
- The block grants the memory round-robin and drives its address (MAR) one element per cycle.
- Over the selected window it computes the signed maximum and the number of completed peaks (rise followed by fall), then returns both with a DONE pulse tagged by requester ID.

Parameters:
- AW, 5, memory address width (32 entries; address arithmetic wraps modulo 2^AW)
- DW, 9, memory data width, two's complement
- NW, 5, peak-count width

Ports:
- CLOCK  in  1  system clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- REQ  in  2  level request per requester; bit i = requester i
- BASE0  in  AW  start address for requester 0, sampled at grant
- LEN0  in  AW  element count minus one for requester 0, sampled at grant
- BASE1  in  AW  start address for requester 1
- LEN1  in  AW  element count minus one for requester 1
- MEM_DATA  in  DW  combinational memory read data for current MAR
- MAR  out  AW  registered memory address
- GNT  out  2  one-hot grant, held for the whole scan
- BUSY  out  1  high in any state other than IDLE
- DONE  out  1  one-cycle completion pulse
- DONE_ID  out  1  requester served by the latest DONE
- MAX_OUT  out  DW  signed maximum of the window
- NUM_OUT  out  NW  peak count of the window

Behaviour:
- One clock (CLOCK). Reset is synchronous and active-high (RESET).
- Reset:
  - state=IDLE; MAR, GNT, BUSY, DONE, DONE_ID, MAX_OUT, NUM_OUT = 0.
  - Internal TEMP, MAX, NUM, FLAG, CNT = 0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- Reset mid-scan: abort immediately; no DONE is issued and all results are cleared.
- States: IDLE, LOAD, SCAN, FIN.
- IDLE:
  - If REQ!=0, pick a requester. Single request: that requester. Both: the one not equal to last.
  - Next cycle: GNT=onehot(sel), MAR=BASE_sel, CNT=LEN_sel; go to LOAD.
- LOAD: MAX=TEMP=MEM_DATA, NUM=0, FLAG=0.
  - If CNT==0, go to FIN.
  - Else MAR=MAR+1 (wraps 31->0), CNT=CNT-1, go to SCAN.
- SCAN: all comparisons are signed DW-bit.
  - MEM_DATA < TEMP: if FLAG, then NUM=NUM+1 and FLAG=0.
  - MEM_DATA > TEMP: FLAG=1; additionally, if MEM_DATA > MAX, then MAX=MEM_DATA.
  - Equal: no change.
  - Always TEMP=MEM_DATA.
  - If CNT==0, go to FIN; else MAR+1 (wrapping), CNT-1, stay in SCAN.
- FIN:
  - DONE=1 for exactly this cycle; DONE_ID=sel; MAX_OUT=MAX; NUM_OUT=NUM.
  - GNT=0; last=sel; go to IDLE.
  - MAX_OUT, NUM_OUT and DONE_ID hold until the next FIN or reset.
- Latency: with REQ sampled in IDLE at cycle 0, LOAD is cycle 1, SCAN is cycles 2..LEN+1, DONE is cycle LEN+2. LEN=0 gives DONE at cycle 2.
- Throughput: one idle cycle between scans minimum.
- Sampling: BASE/LEN are sampled only on the IDLE->LOAD edge; later changes are ignored.
- REQ dropped mid-scan: the scan still completes and DONE is still issued.
- REQ still high in the IDLE cycle after DONE is treated as a new request. With both requesting, the grant alternates.
- Peak-count range: NUM cannot exceed 16 for at most 32 elements, so NW=5 needs no saturation.
- MAR equals the memory address in every state. In IDLE, MAR holds its last value.

Test Plan:
- Basic peaks: bench ROM[0..4] = 10, 20, 5, 30, 7; REQ=01, BASE0=0, LEN0=4.
  - Expected: MAR sequence 0,1,2,3,4; GNT=01.
  - Expected: DONE at cycle 6 with DONE_ID=0, MAX_OUT=30, NUM_OUT=2.
- Negatives: ROM[8..10] = 0x1F6, 0x1F5, 0x1E3 (-10, -11, -29); REQ=10, BASE1=8, LEN1=2.
  - Expected: DONE_ID=1, MAX_OUT=0x1F6, NUM_OUT=0.
- Wrap-around: BASE0=30, LEN0=3.
  - Expected: MAR sequence 30, 31, 0, 1; DONE at cycle 5.
- Arbitration:
  - REQ=11 from reset: first GNT=01, then GNT=10 after one IDLE cycle.
  - Held REQ=11 after that: GNT=01 again (strict alternation).
  - Single REQ=10 twice in a row: GNT=10 both times.
- Single element: LEN0=0, ROM[BASE0]=0x1CE (-50).
  - Expected: DONE at cycle 2, MAX_OUT=0x1CE, NUM_OUT=0.
- Reset mid-scan: RESET=1 at cycle 3 of a LEN=10 scan.
  - Expected next cycle: GNT=0, BUSY=0, MAX_OUT=0, NUM_OUT=0, and no DONE pulse.
